btb_update_ctrl: RTL and testbench

Sequences all writes into the 8-entry branch target buffer. Resolved-branch outcomes from stage 3 are buffered in a small update queue and drained to the BTB write port only on non-stalled cycles. A cache-maintenance request (fence.i / context switch) runs an invalidate walk over every BTB index, and this walk has priority over queued updates. Sits between the EX-stage branch resolver and the BTB write/invalidate ports.

---
 rtl/btb_pkg.sv | 18 +
 rtl/btb_upd_fifo.sv | 85 ++++++++
 rtl/btb_update_ctrl.sv | 133 +++++++++++++
 tb/tb_btb_update_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared types and sizes for the BTB update controller
package btb_pkg;

  localparam int BTB_ENTRIES = 8;
  localparam int BTB_IDX_W   = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } btb_upd_t;

  typedef enum logic {
    RUN   = 1'b0,
    INVAL = 1'b1
  } btb_state_e;

endpackage

// File: rtl/btb_upd_fifo.sv
// rtl/btb_upd_fifo.sv - circular FIFO of resolved-branch updates with flush
// Optional BTBUPD_COALESCE_EN adds an in-place overwrite of the newest entry.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  btb_upd_t         push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
`ifdef BTBUPD_COALESCE_EN
  input  logic             ovr_i,
  output btb_upd_t         last_o,
`endif
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output btb_upd_t         head_o
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  btb_upd_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_DEPTH);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

`ifdef BTBUPD_COALESCE_EN
  assign last_o = mem_q[wr_ptr_q - PTR_ONE];
`endif

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: head_o is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
`ifdef BTBUPD_COALESCE_EN
    if (ovr_i && !flush_i) begin
      mem_q[wr_ptr_q - PTR_ONE].target <= push_data_i.target;
      mem_q[wr_ptr_q - PTR_ONE].taken  <= push_data_i.taken;
    end
`endif
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - sequences BTB updates and the invalidate walk
// Optional BTBUPD_COALESCE_EN merges a push into the newest queued entry with the same PC.
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ENTRIES = BTB_ENTRIES,
  localparam int IDX_W  = $clog2(ENTRIES),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             memory_stall,
  input  logic             res_valid,
  input  logic [31:0]      res_pc,
  input  logic [31:0]      res_target,
  input  logic             res_taken,
  output logic             res_ready,
  output logic             drop,
  output logic             upd_valid,
  output logic [31:0]      upd_pc,
  output logic [31:0]      upd_target,
  output logic             upd_taken,
  input  logic             upd_ready,
  input  logic             inval_req,
  output logic             inval_busy,
  output logic             inv_we,
  output logic [IDX_W-1:0] inv_idx
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENTRIES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  btb_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             drop_q, drop_d;

  logic             inval_accept;
  logic             push_en;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  btb_upd_t         res_entry;
  btb_upd_t         head;

  assign res_entry = '{pc: res_pc, target: res_target, taken: res_taken};

  assign inval_accept = (state_q == RUN) && inval_req;

  assign upd_valid  = (state_q == RUN) && !fifo_empty && !memory_stall;
  assign fifo_pop   = upd_valid && upd_ready;
  assign upd_pc     = head.pc;
  assign upd_target = head.target;
  assign upd_taken  = head.taken;

`ifdef BTBUPD_COALESCE_EN
  btb_upd_t last;
  logic     coalesce_hit;

  // The newest entry is also the head only when one entry is queued.
  assign coalesce_hit = (state_q == RUN) && !fifo_empty && (last.pc == res_pc)
                     && !(fifo_pop && (fifo_count == CNT_W'(1)));
  assign res_ready    = ((state_q == RUN) && !fifo_full) || coalesce_hit;
  assign push_en      = res_valid && res_ready && !inval_accept;
  assign fifo_push    = push_en && !coalesce_hit;
`else
  assign res_ready = (state_q == RUN) && !fifo_full;
  assign push_en   = res_valid && res_ready && !inval_accept;
  assign fifo_push = push_en;
`endif

  assign drop_d = res_valid && !res_ready && !inval_req;
  assign drop   = drop_q;

  btb_upd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_data_i (res_entry),
    .pop_i       (fifo_pop),
    .flush_i     (inval_accept),
`ifdef BTBUPD_COALESCE_EN
    .ovr_i       (push_en && coalesce_hit),
    .last_o      (last),
`endif
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    inv_we     = 1'b0;
    inv_idx    = idx_q;
    inval_busy = (state_q == INVAL);
    case (state_q)
      RUN: begin
        if (inval_req) state_d = INVAL;
      end
      INVAL: begin
        if (!memory_stall) begin
          inv_we = 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = RUN;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      idx_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb/tb_btb_update_ctrl.sv - directed self-checking bench for btb_update_ctrl
module tb_btb_update_ctrl;

  logic        clk;
  logic        rst_n;
  logic        memory_stall;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [31:0] res_target;
  logic        res_taken;
  logic        res_ready;
  logic        drop;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_ready;
  logic        inval_req;
  logic        inval_busy;
  logic        inv_we;
  logic [2:0]  inv_idx;

  int n_assert = 0;
  int n_fail   = 0;

  btb_update_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .memory_stall (memory_stall),
    .res_valid    (res_valid),
    .res_pc       (res_pc),
    .res_target   (res_target),
    .res_taken    (res_taken),
    .res_ready    (res_ready),
    .drop         (drop),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_target   (upd_target),
    .upd_taken    (upd_taken),
    .upd_ready    (upd_ready),
    .inval_req    (inval_req),
    .inval_busy   (inval_busy),
    .inv_we       (inv_we),
    .inv_idx      (inv_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the edge; checks happen 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_res(input logic v, input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    res_valid  = v;
    res_pc     = pc;
    res_target = tgt;
    res_taken  = tk;
  endtask

  initial begin
    rst_n        = 1'b0;
    memory_stall = 1'b0;
    upd_ready    = 1'b0;
    inval_req    = 1'b0;
    set_res(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_res_ready", 64'(res_ready), 64'd1);
    chk("rst_drop", 64'(drop), 64'd0);
    chk("rst_upd_valid", 64'(upd_valid), 64'd0);
    chk("rst_upd_pc", 64'(upd_pc), 64'd0);
    chk("rst_upd_target", 64'(upd_target), 64'd0);
    chk("rst_upd_taken", 64'(upd_taken), 64'd0);
    chk("rst_inval_busy", 64'(inval_busy), 64'd0);
    chk("rst_inv_we", 64'(inv_we), 64'd0);
    chk("rst_inv_idx", 64'(inv_idx), 64'd0);

    // Basic drain
    upd_ready = 1'b1;
    set_res(1'b1, 32'h100, 32'h200, 1'b1);
    #1;
    chk("basic_no_bypass", 64'(upd_valid), 64'd0);
    tick();
    set_res(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("basic_valid", 64'(upd_valid), 64'd1);
    chk("basic_pc", 64'(upd_pc), 64'h100);
    chk("basic_target", 64'(upd_target), 64'h200);
    chk("basic_taken", 64'(upd_taken), 64'd1);
    tick();
    #1;
    chk("basic_empty", 64'(upd_valid), 64'd0);
    chk("basic_empty_pc", 64'(upd_pc), 64'd0);

    // Stall hold
    memory_stall = 1'b1;
    set_res(1'b1, 32'h110, 32'h1110, 1'b0);
    tick();
    set_res(1'b1, 32'h120, 32'h1120, 1'b1);
    tick();
    set_res(1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_hold", 64'(upd_valid), 64'd0);
      tick();
    end
    memory_stall = 1'b0;
    #1;
    chk("stall_rel0_valid", 64'(upd_valid), 64'd1);
    chk("stall_rel0_pc", 64'(upd_pc), 64'h110);
    chk("stall_rel0_taken", 64'(upd_taken), 64'd0);
    tick();
    #1;
    chk("stall_rel1_valid", 64'(upd_valid), 64'd1);
    chk("stall_rel1_pc", 64'(upd_pc), 64'h120);
    tick();
    #1;
    chk("stall_done", 64'(upd_valid), 64'd0);

    // Full and drop
    upd_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      set_res(1'b1, 32'h200 + 32'(i * 4), 32'h2000 + 32'(i), 1'b1);
      #1;
      chk("full_ready", 64'(res_ready), (i <= 4) ? 64'd1 : 64'd0);
      chk("full_no_drop", 64'(drop), 64'd0);
      tick();
    end
    set_res(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("full_drop_pulse", 64'(drop), 64'd1);
    tick();
    #1;
    chk("full_drop_clear", 64'(drop), 64'd0);
    upd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("full_drain_valid", 64'(upd_valid), 64'd1);
      chk("full_drain_pc", 64'(upd_pc), 64'(32'h200 + 32'(i * 4)));
      chk("full_drain_tgt", 64'(upd_target), 64'(32'h2000 + 32'(i)));
      tick();
    end
    #1;
    chk("full_drained", 64'(upd_valid), 64'd0);

    // Invalidate walk with one stalled cycle; push on the accept cycle is discarded
    upd_ready = 1'b0;
    set_res(1'b1, 32'h400, 32'h4000, 1'b1);
    tick();
    set_res(1'b1, 32'h404, 32'h4004, 1'b0);
    tick();
    set_res(1'b1, 32'h999, 32'h9999, 1'b1);
    inval_req = 1'b1;
    tick();
    inval_req = 1'b0;
    set_res(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("inval_busy", 64'(inval_busy), 64'd1);
    chk("inval_no_drop", 64'(drop), 64'd0);
    chk("inval_upd_valid", 64'(upd_valid), 64'd0);
    chk("inval_res_ready", 64'(res_ready), 64'd0);
    for (int k = 0; k < 9; k++) begin
      memory_stall = (k == 3);
      #1;
      chk("walk_busy", 64'(inval_busy), 64'd1);
      chk("walk_we", 64'(inv_we), (k == 3) ? 64'd0 : 64'd1);
      chk("walk_idx", 64'(inv_idx), (k <= 3) ? 64'(k) : 64'(k - 1));
      tick();
    end
    memory_stall = 1'b0;
    #1;
    chk("walk_exit_busy", 64'(inval_busy), 64'd0);
    chk("walk_exit_we", 64'(inv_we), 64'd0);
    chk("walk_exit_idx", 64'(inv_idx), 64'd0);
    chk("walk_exit_ready", 64'(res_ready), 64'd1);
    chk("walk_exit_flushed", 64'(upd_valid), 64'd0);

    // Wrap-around with simultaneous push and pop at count=1
    upd_ready = 1'b1;
    set_res(1'b1, 32'h300, 32'h3300, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      set_res(1'b1, 32'h301 + 32'(i), 32'h3301 + 32'(i), 1'(i));
      #1;
      chk("wrap_valid", 64'(upd_valid), 64'd1);
      chk("wrap_pc", 64'(upd_pc), 64'(32'h300 + 32'(i)));
      chk("wrap_ready", 64'(res_ready), 64'd1);
      tick();
    end
    set_res(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("wrap_last_pc", 64'(upd_pc), 64'h30a);
    chk("wrap_last_tgt", 64'(upd_target), 64'h330a);
    tick();
    #1;
    chk("wrap_empty", 64'(upd_valid), 64'd0);

    // Reset mid-walk
    inval_req = 1'b1;
    tick();
    inval_req = 1'b0;
    tick();
    tick();
    tick();
    #1;
    chk("midrst_idx3", 64'(inv_idx), 64'd3);
    chk("midrst_we", 64'(inv_we), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst_busy", 64'(inval_busy), 64'd0);
    chk("midrst_inv_we", 64'(inv_we), 64'd0);
    chk("midrst_inv_idx", 64'(inv_idx), 64'd0);
    chk("midrst_ready", 64'(res_ready), 64'd1);
    chk("midrst_empty", 64'(upd_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
